// File: rtl/data_memory_sized.sv
// Sized MEM-stage data memory: byte-lane stores, sized/sign-extended registered loads,
// alignment and range error flags, and an optional post-reset clear sweep.
module data_memory_sized #(
  parameter int unsigned DEPTH          = 2048,
  parameter string       DATA_MEM       = "test.mem",
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  AccessSize,
  input  logic        SignExtend,
  input  logic        ErrClear,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Busy,
  output logic        MisalignErr,
  output logic        RangeErr
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e          stateQ, stateD;
  logic [IdxW-1:0] cntQ, cntD;
  logic [31:0]     readDataQ, readDataD;
  logic            readValidQ, readValidD;
  logic            misErrQ, misErrD;
  logic            rngErrQ, rngErrD;

  logic [31:0]     mem [DEPTH];

  logic            idle, inRange, misalign, accessOk, storeEn;
  logic [IdxW-1:0] idx;
  logic [3:0]      byteEn;
  logic [31:0]     wrLanes, rdWord, shifted, loadVal;

  assign idle    = (stateQ == StIdle);
  assign idx     = Address[IdxW+1:2];
  assign inRange = ({2'b00, Address[31:2]} < DEPTH);

  always_comb begin
    misalign = 1'b0;
    byteEn   = 4'b0000;
    wrLanes  = WriteData;
    loadVal  = 32'h0;
    rdWord   = mem[idx];
    // Aligned accesses only ever need the byte offset as shift amount.
    shifted  = rdWord >> {Address[1:0], 3'b000};
    unique case (AccessSize)
      2'b00: begin
        byteEn  = 4'b0001 << Address[1:0];
        wrLanes = {4{WriteData[7:0]}};
        loadVal = {{24{SignExtend & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misalign = Address[0];
        byteEn   = Address[1] ? 4'b1100 : 4'b0011;
        wrLanes  = {2{WriteData[15:0]}};
        loadVal  = {{16{SignExtend & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        misalign = (Address[1:0] != 2'b00);
        byteEn   = 4'b1111;
        loadVal  = rdWord;
      end
      default: misalign = 1'b1;
    endcase
  end

  assign accessOk = ~misalign & inRange;
  assign storeEn  = idle & MemWrite & accessOk & ~Reset;

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    readDataD  = readDataQ;
    readValidD = 1'b0;
    misErrD    = misErrQ & ~ErrClear;
    rngErrD    = rngErrQ & ~ErrClear;
    if (stateQ == StClear) begin
      cntD = cntQ + 1'b1;
      if (cntQ == LastIdx) begin
        stateD = StIdle;
        cntD   = '0;
      end
    end else begin
      if (MemRead) begin
        readValidD = 1'b1;
        readDataD  = accessOk ? loadVal : 32'h0;
      end
      if (MemRead || MemWrite) begin
        if (misalign) misErrD = 1'b1;
        if (!inRange) rngErrD = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ     <= CLEAR_ON_RESET ? StClear : StIdle;
      cntQ       <= '0;
      readDataQ  <= 32'h0;
      readValidQ <= 1'b0;
      misErrQ    <= 1'b0;
      rngErrQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      readDataQ  <= readDataD;
      readValidQ <= readValidD;
      misErrQ    <= misErrD;
      rngErrQ    <= rngErrD;
    end
  end

  // Array has no reset; Reset only blocks writes while asserted.
  always_ff @(posedge Clk) begin
    if (!Reset && stateQ == StClear) begin
      mem[cntQ] <= 32'h0;
    end else if (storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[idx][8*b +: 8] <= wrLanes[8*b +: 8];
      end
    end
  end

  assign ReadData    = readDataQ;
  assign ReadValid   = readValidQ;
  assign Busy        = (stateQ == StClear);
  assign MisalignErr = misErrQ;
  assign RangeErr    = rngErrQ;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: vector table on a plain instance plus
// hand-written clear-sweep sequences on a CLEAR_ON_RESET instance.
module tb_data_memory_sized;

  localparam int unsigned Depth = 16;

  logic        Clk = 1'b0;
  logic        rst, rstClr;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead, SignExtend, ErrClear;
  logic [1:0]  AccessSize;

  logic [31:0] readData, readDataClr;
  logic        readValid, busy, misErr, rngErr;
  logic        readValidClr, busyClr, misErrClr, rngErrClr;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  data_memory_sized #(.DEPTH(Depth), .DATA_MEM(""), .CLEAR_ON_RESET(1'b0)) dut (
    .Clk(Clk), .Reset(rst), .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .AccessSize(AccessSize), .SignExtend(SignExtend), .ErrClear(ErrClear),
    .ReadData(readData), .ReadValid(readValid), .Busy(busy), .MisalignErr(misErr),
    .RangeErr(rngErr)
  );

  data_memory_sized #(.DEPTH(Depth), .DATA_MEM(""), .CLEAR_ON_RESET(1'b1)) dutClr (
    .Clk(Clk), .Reset(rstClr), .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .AccessSize(AccessSize), .SignExtend(SignExtend), .ErrClear(ErrClear),
    .ReadData(readDataClr), .ReadValid(readValidClr), .Busy(busyClr), .MisalignErr(misErrClr),
    .RangeErr(rngErrClr)
  );

  typedef struct {
    logic        we, re;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        sext, eclr;
    logic        expValid;
    logic [31:0] expData;
    logic        expMis, expRng;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                     input logic eclr, input logic ev, input logic [31:0] ed,
                     input logic em, input logic er);
    vec_t v;
    v = '{we, re, addr, wdata, size, sext, eclr, ev, ed, em, er};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                       input logic eclr);
    MemWrite = we; MemRead = re; Address = addr; WriteData = wdata;
    AccessSize = size; SignExtend = sext; ErrClear = eclr;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rstClr = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);

    //   we  re  addr    wdata          sz  sx  ec  | v  data           mis rng
    add(1, 0, 32'h00, 32'hCAFEF00D, 2, 0, 0,   0, 32'h00000000, 0, 0);
    add(1, 0, 32'h10, 32'hDEADBEEF, 2, 0, 0,   0, 32'h00000000, 0, 0);
    add(0, 1, 32'h10, 32'h0,        2, 0, 0,   1, 32'hDEADBEEF, 0, 0);
    add(0, 0, 32'h10, 32'h0,        2, 0, 0,   0, 32'hDEADBEEF, 0, 0);
    add(1, 0, 32'h10, 32'h11223344, 2, 0, 0,   0, 32'hDEADBEEF, 0, 0);
    add(1, 0, 32'h13, 32'h0000007F, 0, 0, 0,   0, 32'hDEADBEEF, 0, 0);
    add(0, 1, 32'h10, 32'h0,        2, 0, 0,   1, 32'h7F223344, 0, 0);
    add(0, 1, 32'h13, 32'h0,        0, 1, 0,   1, 32'h0000007F, 0, 0);
    add(1, 0, 32'h12, 32'h12345680, 0, 0, 0,   0, 32'h0000007F, 0, 0);
    add(0, 1, 32'h12, 32'h0,        0, 1, 0,   1, 32'hFFFFFF80, 0, 0);
    add(0, 1, 32'h12, 32'h0,        0, 0, 0,   1, 32'h00000080, 0, 0);
    add(1, 0, 32'h10, 32'h1234BEEF, 1, 0, 0,   0, 32'h00000080, 0, 0);
    add(0, 1, 32'h10, 32'h0,        2, 0, 0,   1, 32'h7F80BEEF, 0, 0);
    add(0, 1, 32'h10, 32'h0,        1, 1, 0,   1, 32'hFFFFBEEF, 0, 0);
    add(0, 1, 32'h10, 32'h0,        1, 0, 0,   1, 32'h0000BEEF, 0, 0);
    add(0, 1, 32'h12, 32'h0,        1, 1, 0,   1, 32'h00007F80, 0, 0);
    add(0, 1, 32'h11, 32'h0,        0, 1, 0,   1, 32'hFFFFFFBE, 0, 0);
    add(0, 1, 32'h11, 32'h0,        1, 0, 0,   1, 32'h00000000, 1, 0);
    add(1, 0, 32'h11, 32'h0000FFFF, 1, 0, 0,   0, 32'h00000000, 1, 0);
    add(0, 1, 32'h10, 32'h0,        2, 0, 0,   1, 32'h7F80BEEF, 1, 0);
    add(0, 0, 32'h0,  32'h0,        2, 0, 1,   0, 32'h7F80BEEF, 0, 0);
    add(1, 0, 32'h40, 32'h12345678, 2, 0, 0,   0, 32'h7F80BEEF, 0, 1);
    add(0, 1, 32'h40, 32'h0,        2, 0, 0,   1, 32'h00000000, 0, 1);
    add(0, 1, 32'h00, 32'h0,        2, 0, 0,   1, 32'hCAFEF00D, 0, 1);
    add(0, 1, 32'h20, 32'h0,        3, 0, 0,   1, 32'h00000000, 1, 1);
    add(0, 1, 32'h22, 32'h0,        2, 0, 1,   1, 32'h00000000, 1, 0);
    add(0, 0, 32'h0,  32'h0,        2, 0, 1,   0, 32'h00000000, 0, 0);
    add(0, 1, 32'h41, 32'h0,        2, 0, 0,   1, 32'h00000000, 1, 1);
    add(0, 0, 32'h0,  32'h0,        2, 0, 1,   0, 32'h00000000, 0, 0);
    add(1, 0, 32'h08, 32'h00000005, 2, 0, 0,   0, 32'h00000000, 0, 0);
    add(1, 1, 32'h08, 32'hAAAAAAAA, 2, 0, 0,   1, 32'h00000005, 0, 0);
    add(0, 1, 32'h08, 32'h0,        2, 0, 0,   1, 32'hAAAAAAAA, 0, 0);
    add(0, 1, 32'h00, 32'h0,        2, 0, 0,   1, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h10, 32'h0,        2, 0, 0,   1, 32'h7F80BEEF, 0, 0);
    add(1, 0, 32'h3C, 32'h0F0F0F0F, 2, 0, 0,   0, 32'h7F80BEEF, 0, 0);
    add(1, 0, 32'h3F, 32'h000000A5, 0, 0, 0,   0, 32'h7F80BEEF, 0, 0);
    add(0, 1, 32'h3C, 32'h0,        2, 0, 0,   1, 32'hA50F0F0F, 0, 0);
    add(0, 1, 32'h3E, 32'h0,        1, 0, 0,   1, 32'h0000A50F, 0, 0);
    add(1, 0, 32'h01, 32'h00000055, 0, 0, 0,   0, 32'h0000A50F, 0, 0);
    add(0, 1, 32'h00, 32'h0,        2, 0, 0,   1, 32'hCAFE550D, 0, 0);

    #12;
    rst = 1'b0;
    rstClr = 1'b0;
    chk("reset_data", readData, 32'h0);
    chk("reset_valid", {31'b0, readValid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_mis", {31'b0, misErr}, 32'h0);
    chk("reset_rng", {31'b0, rngErr}, 32'h0);
    chk("reset_busy_clr", {31'b0, busyClr}, 32'h1);
    chk("reset_data_clr", readDataClr, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].size,
            vecs[i].sext, vecs[i].eclr);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, readValid}, {31'b0, vecs[i].expValid});
      chk($sformatf("v%0d_data", i), readData, vecs[i].expData);
      chk($sformatf("v%0d_mis", i), {31'b0, misErr}, {31'b0, vecs[i].expMis});
      chk($sformatf("v%0d_rng", i), {31'b0, rngErr}, {31'b0, vecs[i].expRng});
    end

    // Clear sweep: fill with ones, then reset the clearing instance.
    for (int w = 0; w < Depth; w++) begin
      drive(1'b1, 1'b0, 32'(4 * w), 32'hFFFFFFFF, 2'b10, 1'b0, 1'b0);
      step();
    end
    chk("clr_idle_before", {31'b0, busyClr}, 32'h0);
    drive(1'b0, 1'b1, 32'h41, 32'h0, 2'b10, 1'b0, 1'b0);
    rstClr = 1'b1;
    #2;
    rstClr = 1'b0;
    chk("clr_busy_after_reset", {31'b0, busyClr}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("clr_ignore%0d_valid", k), {31'b0, readValidClr}, 32'h0);
      chk($sformatf("clr_ignore%0d_mis", k), {31'b0, misErrClr}, 32'h0);
      chk($sformatf("clr_ignore%0d_rng", k), {31'b0, rngErrClr}, 32'h0);
      chk($sformatf("clr_ignore%0d_busy", k), {31'b0, busyClr}, 32'h1);
    end

    // Reset mid-sweep must restart the full count.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);
    rstClr = 1'b1;
    step();
    rstClr = 1'b0;
    n = 0;
    while (busyClr && n < 100) begin
      step();
      n++;
    end
    chk("clr_busy_cycles", 32'(n), 32'd16);

    for (int w = 0; w < Depth; w++) begin
      drive(1'b0, 1'b1, 32'(4 * w), 32'h0, 2'b10, 1'b0, 1'b0);
      step();
      chk($sformatf("clr_word%0d_valid", w), {31'b0, readValidClr}, 32'h1);
      chk($sformatf("clr_word%0d_data", w), readDataClr, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);
    step();
    chk("clr_valid_drops", {31'b0, readValidClr}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
